// File: rtl/time_set_if.sv
// time_set_if: raw board buttons into the time-set controller, increment strobes and status back out.
interface time_set_if;
    logic button_hr;
    logic button_min;
    logic button_test;
    logic inc_hr;
    logic inc_min;
    logic hold_sec;
    logic test_mode;
    logic busy;
    modport master (
        output button_hr, button_min, button_test,
        input  inc_hr, inc_min, hold_sec, test_mode, busy
    );
    modport slave (
        input  button_hr, button_min, button_test,
        output inc_hr, inc_min, hold_sec, test_mode, busy
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces/arbitrates hour+minute set buttons into one-cycle increment strobes and toggles test mode.
// Define TIME_SET_AUTOREPEAT_EN to build the auto-repeat (HOLD expiry and RPT); otherwise one strobe per press.
module time_set_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_PERIOD = 25000000,
    parameter int CNT_W      = 26
) (
    input  logic      clk_i,
    input  logic      rst_i,
    time_set_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DEB, FIRST, HOLD, RPT, REL} state_t;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
`ifdef TIME_SET_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PERIOD - 1);
`endif
    if (CNT_W < $clog2(DEB_CYCLES + 1) || CNT_W < $clog2(REP_DELAY + 1) ||
        CNT_W < $clog2(REP_PERIOD + 1)) begin : g_width_chk
        $error("time_set_ctrl: CNT_W too narrow for the configured cycle counts");
    end
    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_hr_q, inc_hr_d;
    logic             inc_min_q, inc_min_d;
    logic [1:0]       hr_sync_q, min_sync_q, test_sync_q;
    logic             tst_stable_q, tst_stable_d;
    logic [CNT_W-1:0] tst_cnt_q, tst_cnt_d;
    logic             test_mode_q, test_mode_d;
    logic             hr_s, min_s, test_s, btn, strobe;
    assign hr_s   = hr_sync_q[1];
    assign min_s  = min_sync_q[1];
    assign test_s = test_sync_q[1];
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            cnt_q        <= '0;
            inc_hr_q     <= 1'b0;
            inc_min_q    <= 1'b0;
            hr_sync_q    <= '0;
            min_sync_q   <= '0;
            test_sync_q  <= '0;
            tst_stable_q <= 1'b0;
            tst_cnt_q    <= '0;
            test_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            inc_hr_q     <= inc_hr_d;
            inc_min_q    <= inc_min_d;
            hr_sync_q    <= {hr_sync_q[0], bus.button_hr};
            min_sync_q   <= {min_sync_q[0], bus.button_min};
            test_sync_q  <= {test_sync_q[0], bus.button_test};
            tst_stable_q <= tst_stable_d;
            tst_cnt_q    <= tst_cnt_d;
            test_mode_q  <= test_mode_d;
        end
    end
    // Only the selected button is watched once DEB is entered; the other waits for IDLE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        strobe  = 1'b0;
        btn     = sel_q ? hr_s : min_s;
        case (state_q)
            IDLE: begin
                if (hr_s || min_s) begin
                    sel_d   = hr_s;
                    cnt_d   = '0;
                    state_d = DEB;
                end
            end
            DEB: begin
                if (!btn) state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = FIRST;
                else cnt_d = cnt_q + 1'b1;
            end
            FIRST: begin
                strobe  = 1'b1;
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!btn) begin
                    cnt_d   = '0;
                    state_d = REL;
                end
`ifdef TIME_SET_AUTOREPEAT_EN
                else if (cnt_q == DLY_LAST) begin
                    strobe  = 1'b1;
                    cnt_d   = '0;
                    state_d = RPT;
                end else cnt_d = cnt_q + 1'b1;
`endif
            end
`ifdef TIME_SET_AUTOREPEAT_EN
            RPT: begin
                if (!btn) begin
                    cnt_d   = '0;
                    state_d = REL;
                end else if (cnt_q == PER_LAST) begin
                    strobe = 1'b1;
                    cnt_d  = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
`endif
            REL: begin
                if (btn) cnt_d = '0;
                else if (cnt_q == DEB_LAST) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        inc_hr_d  = strobe && sel_q;
        inc_min_d = strobe && !sel_q;
    end
    // Test debouncer tracks the accepted level; only an accepted 0->1 change toggles the mode.
    always_comb begin
        tst_stable_d = tst_stable_q;
        tst_cnt_d    = '0;
        test_mode_d  = test_mode_q;
        if (test_s != tst_stable_q) begin
            if (tst_cnt_q == DEB_LAST) begin
                tst_stable_d = test_s;
                test_mode_d  = test_mode_q ^ test_s;
            end else tst_cnt_d = tst_cnt_q + 1'b1;
        end
    end
    assign bus.inc_hr    = inc_hr_q;
    assign bus.inc_min   = inc_min_q;
    assign bus.hold_sec  = state_q inside {DEB, FIRST, HOLD, RPT};
    assign bus.busy      = state_q != IDLE;
    assign bus.test_mode = test_mode_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench for time_set_ctrl with DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8.
// Cycle i below is the interval after the i-th rising edge, counting the first edge that samples the press as 0.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   failures = 0;
    time_set_if bus ();
    time_set_ctrl #(
        .DEB_CYCLES(4),
        .REP_DELAY (20),
        .REP_PERIOD(8),
        .CNT_W     (6)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    function automatic logic [3:0] outs();
        return {bus.inc_hr, bus.inc_min, bus.hold_sec, bus.busy};
    endfunction
    function automatic logic min_pulse(input int i);
`ifdef TIME_SET_AUTOREPEAT_EN
        return i == 7 || i == 27 || i == 35 || i == 43 || i == 51 || i == 59;
`else
        return i == 7;
`endif
    endfunction
    initial begin
        bus.button_hr = 1'b0;
        bus.button_min = 1'b0;
        bus.button_test = 1'b0;
        // reset with buttons toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outs@%0d", i), outs(), 4'b0000);
            check($sformatf("reset_test_mode@%0d", i), {3'b000, bus.test_mode}, 4'b0000);
            bus.button_hr = ~bus.button_hr;
            bus.button_min = ~bus.button_min;
            bus.button_test = ~bus.button_test;
        end
        @(negedge clk);
        bus.button_hr = 1'b0;
        bus.button_min = 1'b0;
        bus.button_test = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        check("post_reset_outs", outs(), 4'b0000);
        repeat (5) @(negedge clk);
        // clean hour press held 10 cycles
        bus.button_hr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("hr_press@%0d", i), outs(),
                  {i == 7, 1'b0, i >= 2 && i <= 11, i >= 2 && i <= 15});
            if (i == 9) bus.button_hr = 1'b0;
        end
        repeat (5) @(negedge clk);
        // minute press held 60 cycles
        bus.button_min = 1'b1;
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            check($sformatf("min_hold@%0d", i), outs(),
                  {1'b0, min_pulse(i), i >= 2 && i <= 61, i >= 2 && i <= 65});
            if (i == 59) bus.button_min = 1'b0;
        end
        repeat (5) @(negedge clk);
        // bounce: high 2, low 1, high 2, low
        bus.button_min = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("bounce@%0d", i), outs(),
                  {2'b00, i == 2 || i == 3 || i == 5 || i == 6, i == 2 || i == 3 || i == 5 || i == 6});
            if (i == 1 || i == 4) bus.button_min = 1'b0;
            if (i == 2) bus.button_min = 1'b1;
        end
        repeat (5) @(negedge clk);
        // simultaneous hour+minute press, hours wins
        bus.button_hr = 1'b1;
        bus.button_min = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check($sformatf("simul@%0d", i), outs(),
                  {i == 7, 1'b0, i >= 2 && i <= 11, i >= 2 && i <= 15});
            if (i == 9) begin
                bus.button_hr = 1'b0;
                bus.button_min = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        // test button: press 10, release 10, press 10, later a 2-cycle glitch
        bus.button_test = 1'b1;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            check($sformatf("test_mode@%0d", i), {bus.test_mode, 2'b00, bus.busy},
                  {i >= 5 && i <= 24, 3'b000});
            if (i == 9 || i == 29 || i == 46) bus.button_test = 1'b0;
            if (i == 19 || i == 44) bus.button_test = 1'b1;
        end
        repeat (5) @(negedge clk);
        // reset in FIRST aborts with no trailing strobe
        bus.button_hr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("abort_pre@%0d", i), outs(),
                  {1'b0, 1'b0, i >= 2, i >= 2});
        end
        rst_i = 1'b0;
        @(negedge clk);
        check("abort_in_reset", outs(), 4'b0000);
        bus.button_hr = 1'b0;
        rst_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("abort_post@%0d", i), outs(), 4'b0000);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Controller that sequences the real-time clock's time-setting datapath.
- Debounces and arbitrates the hour and minute setting buttons, and issues single-cycle increment strobes to the hour and minute counters, with auto-repeat while a button is held.
- Debounces the test button and toggles the fast/test mode select.
- Sits between the raw board buttons and the time counter / prescaler logic of the clock top level.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable cycles required to accept a press or a release.
- REP_DELAY, 50000000: cycles from the first strobe to the first auto-repeat strobe.
- REP_PERIOD, 25000000: cycles between successive auto-repeat strobes.
- CNT_W, 26: width of the shared timing counter; must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-low.
- button_hr_i  in  1  raw hour button, asynchronous, active-high.
- button_min_i  in  1  raw minute button, asynchronous, active-high.
- button_test_i  in  1  raw test button, asynchronous, active-high.
- inc_hr_o  out  1  one-cycle strobe: increment hours.
- inc_min_o  out  1  one-cycle strobe: increment minutes.
- hold_sec_o  out  1  high while a setting button is being serviced; seconds counter frozen.
- test_mode_o  out  1  fast/test mode select; toggles per accepted test press.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_i low at a clk_i edge): all outputs 0; FSM to IDLE; counters and synchronisers cleared. Reset asserted mid-operation aborts immediately, with no trailing strobe.
- Synchronisation: each button passes a 2-FF synchroniser; the logic below sees only the synchronised signals (hr_s, min_s, test_s).
- FSM states: IDLE, DEB, FIRST, HOLD, RPT, REL. A 1-bit sel register records which button is being serviced (0 = minutes, 1 = hours).
- IDLE:
  - If hr_s is high: sel=1, cnt=0, go to DEB.
  - Else if min_s is high: sel=0, cnt=0, go to DEB.
  - If both are high in the same cycle, hours wins.
- DEB:
  - If the selected button is low: go to IDLE, no strobe.
  - Else cnt++.
  - When cnt==DEB_CYCLES-1: go to FIRST.
- FIRST (1 cycle): assert the strobe for sel (inc_hr_o or inc_min_o), cnt=0, go to HOLD.
- HOLD:
  - If released: cnt=0, go to REL.
  - Else when cnt==REP_DELAY-1: strobe, cnt=0, go to RPT.
- RPT:
  - If released: cnt=0, go to REL.
  - Else when cnt==REP_PERIOD-1: strobe, cnt=0, stay in RPT.
- REL:
  - The selected button must stay low for DEB_CYCLES consecutive cycles, then go to IDLE.
  - Any high sample resets cnt and keeps the FSM in REL. Bounce never returns it to HOLD and never produces a strobe.
- Arbitration: the non-selected button is ignored from DEB through REL. It is serviced only after IDLE is re-entered, and only if it is still high then.
- Strobes: inc_hr_o and inc_min_o are never high in the same cycle, and each strobe lasts exactly one cycle.
- First-strobe latency: a clean press sampled at clock edge N gives a strobe at cycle N+DEB_CYCLES+3.
- hold_sec_o = 1 in DEB, FIRST, HOLD and RPT; 0 in IDLE and REL. busy_o = (state != IDLE).
- Test path: an independent debouncer (own counter, DEB_CYCLES).
  - On an accepted rising press, test_mode_o toggles once.
  - A release must be debounced before the next press is accepted.
  - Test presses are not blocked by the FSM.
- Counter wrap: cnt never wraps; it is compared and cleared before reaching 2^CNT_W-1.

Optional Feature:
- Macro: TIME_SET_AUTOREPEAT_EN.
- Defined: HOLD and RPT behave as described above.
- Undefined: HOLD and RPT are not implemented. FIRST goes directly to a wait state that only watches for release (equivalent to HOLD with no REP_DELAY expiry). The result is exactly one strobe per press regardless of hold time; hold_sec_o stays high until release.

Test Plan:
Parameters for all scenarios: DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8.
1. Reset: rst_i=0 for 3 cycles, buttons toggling -> all outputs 0 throughout; busy_o=0 one cycle after release of reset.
2. Clean hour press held 10 cycles, then released -> exactly one inc_hr_o pulse at press+7 cycles; inc_min_o stays 0; hold_sec_o falls on release detection; busy_o=0 after REL completes (4 low cycles).
3. Minute press held 60 cycles, autorepeat on -> inc_min_o pulses at press+7, +27, +35, +43, +51, +59 (6 pulses). With macro off -> single pulse only.
4. Bounce: button_min_i high 2 cycles, low 1, high 2, low -> no strobe; FSM returns to IDLE.
5. Simultaneous hr+min rising in the same cycle, both held 10 cycles -> only inc_hr_o pulses; the minute press is not serviced after release because min is low by then.
6. button_test_i pressed 10 cycles, released 10 cycles, pressed 10 cycles -> test_mode_o goes 0→1→0; a 2-cycle glitch press gives no toggle.
